// File: rtl/conf_int_add__acc_supplier_pkg.sv
// Shared types and sizing for the accurate-result supplier of the approximate adder wrapper.
// No logic; state encoding and width helpers only.
package conf_int_add__pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int OPND_W       = 32;
    localparam int ACC_W        = 33;
    localparam int ERR_CNT_W    = 16;
    localparam int CHUNK_W_DFLT = 8;

    function automatic int chunk_count(input int cw);
        return OPND_W / cw;
    endfunction

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int N_CHUNK     = chunk_count(CHUNK_W_DFLT);
    localparam int CHUNK_IDX_W = idx_width(N_CHUNK);

endpackage

// File: rtl/conf_int_add__acc_supplier_if.sv
// Operand, result and error-counter signals between the supplier and its environment.
// master drives operands/ack/approx result; slave is the supplier.
interface conf_int_add__acc_supplier_if
    import conf_int_add__pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int ERR_W              = ERR_CNT_W
);
    logic                          in_valid;
    logic                          in_ready;
    logic [OPND_W-1:0]             a;
    logic [OPND_W-1:0]             b;
    logic [ACC_W-1:0]              d__acc;
    logic                          acc__sel;
    logic                          out_ack;
    logic [DATA_PATH_BITWIDTH:0]   d__apx;
    logic                          err_clr;
    logic [ERR_W-1:0]              err_cnt;

    modport master (
        output in_valid, a, b, out_ack, d__apx, err_clr,
        input  in_ready, d__acc, acc__sel, err_cnt
    );

    modport slave (
        input  in_valid, a, b, out_ack, d__apx, err_clr,
        output in_ready, d__acc, acc__sel, err_cnt
    );
endinterface

// File: rtl/conf_int_add__acc_supplier_chunk_add.sv
// Combinational W-bit adder slice with carry in/out; zero latency, no flow control.
module conf_int_add__chunk_add #(
    parameter int W = 8
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         ci,
    output logic [W-1:0] s,
    output logic         co
);
    assign {co, s} = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci};
endmodule

// File: rtl/conf_int_add__acc_supplier.sv
// Exact 33-bit sum via one reused chunk adder over N cycles; result valid N edges after accept.
// in_ready only in IDLE; result held on d__acc/acc__sel until out_ack, then compared to d__apx.
module conf_int_add__acc_supplier
    import conf_int_add__pkg::*;
#(
    parameter int DATA_PATH_BITWIDTH = 16,
    parameter int CHUNK_W            = CHUNK_W_DFLT,
    parameter int ERR_W              = ERR_CNT_W
) (
    input  logic                        clk,
    input  logic                        rst,
    conf_int_add__acc_supplier_if.slave bus
);
    localparam int N     = chunk_count(CHUNK_W);
    localparam int IDX_W = idx_width(N);
    localparam int CMP_W = DATA_PATH_BITWIDTH + 1;

    state_t              state_q;
    state_t              state_d;
    logic [OPND_W-1:0]   a_q;
    logic [OPND_W-1:0]   b_q;
    logic [OPND_W-1:0]   work_q;
    logic [OPND_W-1:0]   work_nxt;
    logic [ACC_W-1:0]    acc_q;
    logic                carry_q;
    logic [IDX_W-1:0]    idx_q;
    logic [ERR_W-1:0]    err_q;
    logic [CHUNK_W-1:0]  chunk_s;
    logic                chunk_co;
    logic                last_chunk;
    logic                ack_hold;
    logic                mismatch;

    conf_int_add__chunk_add #(.W(CHUNK_W)) u_chunk (
        .a  (a_q[idx_q*CHUNK_W +: CHUNK_W]),
        .b  (b_q[idx_q*CHUNK_W +: CHUNK_W]),
        .ci (carry_q),
        .s  (chunk_s),
        .co (chunk_co)
    );

    assign last_chunk = (idx_q == IDX_W'(N - 1));

    // Partial sums build in work_q so d__acc only changes on the edge entering HOLD.
    always_comb begin
        work_nxt = work_q;
        work_nxt[idx_q*CHUNK_W +: CHUNK_W] = chunk_s;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid) state_d = ADD;
            ADD:     if (last_chunk)   state_d = HOLD;
            HOLD:    if (bus.out_ack)  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            a_q     <= '0;
            b_q     <= '0;
            work_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            acc_q   <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.in_valid) begin
                        a_q     <= bus.a;
                        b_q     <= bus.b;
                        carry_q <= 1'b0;
                        idx_q   <= '0;
                    end
                end
                ADD: begin
                    work_q  <= work_nxt;
                    carry_q <= chunk_co;
                    idx_q   <= idx_q + 1'b1;
                    if (last_chunk) begin
                        acc_q <= {chunk_co, work_nxt};
                    end
                end
                default: ;
            endcase
        end
    end

    assign ack_hold = (state_q == HOLD) && bus.out_ack;
    assign mismatch = (acc_q[ACC_W-1 -: CMP_W] != bus.d__apx);

    // Clear wins over a same-edge increment; counter sticks at all-ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            err_q <= '0;
        end else if (bus.err_clr) begin
            err_q <= '0;
        end else if (ack_hold && mismatch && !(&err_q)) begin
            err_q <= err_q + 1'b1;
        end
    end

    assign bus.in_ready = (state_q == IDLE);
    assign bus.acc__sel = (state_q == HOLD);
    assign bus.d__acc   = acc_q;
    assign bus.err_cnt  = err_q;

endmodule

// File: tb/tb_conf_int_add__acc_supplier.sv
// Bench for the accurate-result supplier: directed table, hand-written reset/ignore sequences,
// random operands against a plain-arithmetic model; a 3-bit-counter twin exercises saturation.
module tb_conf_int_add__acc_supplier;

    logic clk = 1'b0;
    logic rst = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;
    int m_err   = 0;
    int s_err   = 0;

    localparam int SAT_W   = 3;
    localparam int MAIN_MX = 65535;
    localparam int SAT_MX  = 7;

    conf_int_add__acc_supplier_if #(.DATA_PATH_BITWIDTH(16), .ERR_W(16))    bus   ();
    conf_int_add__acc_supplier_if #(.DATA_PATH_BITWIDTH(16), .ERR_W(SAT_W)) bus_s ();

    conf_int_add__acc_supplier #(.DATA_PATH_BITWIDTH(16), .CHUNK_W(8), .ERR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    conf_int_add__acc_supplier #(.DATA_PATH_BITWIDTH(16), .CHUNK_W(8), .ERR_W(SAT_W)) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    assign bus_s.in_valid = bus.in_valid;
    assign bus_s.a        = bus.a;
    assign bus_s.b        = bus.b;
    assign bus_s.out_ack  = bus.out_ack;
    assign bus_s.d__apx   = bus.d__apx;
    assign bus_s.err_clr  = bus.err_clr;

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [16:0] apx;
        int          dly;
        logic        clr;
        logic [32:0] exp_sum;
        int          exp_err;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full operation; in_valid and junk operands stay up until the ack edge to prove they are ignored.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [16:0] apx,
                         input int dly, input logic clr, input logic [32:0] exp_sum,
                         input int exp_err, input int exp_err_s);
        int lat;
        bit ready_ok;
        bit hold_ok;
        lat = 0;
        while (bus.in_ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        chk("accept_ready", {63'd0, bus.in_ready}, 64'd1);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        tick();
        bus.a = $urandom;
        bus.b = $urandom;
        lat = 0;
        ready_ok = 1'b1;
        while (bus.acc__sel !== 1'b1 && lat < 12) begin
            if (bus.in_ready !== 1'b0) ready_ok = 1'b0;
            tick();
            lat++;
        end
        chk("acc_sel_latency", 64'(lat), 64'd4);
        chk("in_ready_low_add", {63'd0, ready_ok}, 64'd1);
        chk("sum", {31'd0, bus.d__acc}, {31'd0, exp_sum});
        hold_ok = 1'b1;
        for (int i = 0; i < dly; i++) begin
            if (bus.in_ready !== 1'b0 || bus.acc__sel !== 1'b1 || bus.d__acc !== exp_sum)
                hold_ok = 1'b0;
            tick();
        end
        if (bus.in_ready !== 1'b0 || bus.d__acc !== exp_sum) hold_ok = 1'b0;
        chk("hold_stable", {63'd0, hold_ok}, 64'd1);
        bus.out_ack = 1'b1;
        bus.d__apx  = apx;
        bus.err_clr = clr;
        tick();
        bus.out_ack  = 1'b0;
        bus.err_clr  = 1'b0;
        bus.in_valid = 1'b0;
        chk("acc_sel_after_ack", {63'd0, bus.acc__sel}, 64'd0);
        chk("idle_after_ack", {63'd0, bus.in_ready}, 64'd1);
        chk("sum_kept_after_ack", {31'd0, bus.d__acc}, {31'd0, exp_sum});
        chk("err_cnt", {48'd0, bus.err_cnt}, 64'(exp_err));
        chk("err_cnt_narrow", {61'd0, bus_s.err_cnt}, 64'(exp_err_s));
    endtask

    // Reference: exact sum and the saturating mismatch count, from plain arithmetic.
    task automatic model_op(input logic [31:0] a, input logic [31:0] b, input logic [16:0] apx,
                            input int dly, input logic clr);
        logic [32:0] s;
        logic [16:0] upper;
        s = 33'(a) + 33'(b);
        upper = 17'(s >> 16);
        if (clr) begin
            m_err = 0;
            s_err = 0;
        end else if (upper != apx) begin
            if (m_err < MAIN_MX) m_err++;
            if (s_err < SAT_MX) s_err++;
        end
        do_op(a, b, apx, dly, clr, s, m_err, s_err);
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [32:0] rs;
        logic [16:0] rapx;

        vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0001, 17'h1_0000, 0, 1'b0, 33'h1_0000_0000, 0};
        vecs[1] = '{32'h0001_0000, 32'h0002_0000, 17'h0_0003, 0, 1'b0, 33'h0_0003_0000, 0};
        vecs[2] = '{32'h0001_0000, 32'h0002_0000, 17'h0_0004, 5, 1'b0, 33'h0_0003_0000, 1};
        vecs[3] = '{32'h0001_0000, 32'h0002_0000, 17'h0_0004, 1, 1'b1, 33'h0_0003_0000, 0};
        vecs[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 17'h1_FFFF, 2, 1'b0, 33'h1_FFFF_FFFE, 0};
        vecs[5] = '{32'h1234_5678, 32'h0000_FFFF, 17'h0_0000, 0, 1'b0, 33'h0_1235_5677, 1};

        bus.in_valid = 1'b0;
        bus.a        = '0;
        bus.b        = '0;
        bus.out_ack  = 1'b0;
        bus.d__apx   = '0;
        bus.err_clr  = 1'b0;
        tick();
        tick();
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_acc_sel", {63'd0, bus.acc__sel}, 64'd0);
        chk("rst_d_acc", {31'd0, bus.d__acc}, 64'd0);
        chk("rst_err_cnt", {48'd0, bus.err_cnt}, 64'd0);
        rst = 1'b1;
        tick();

        for (int i = 0; i < 6; i++) begin
            do_op(vecs[i].a, vecs[i].b, vecs[i].apx, vecs[i].dly, vecs[i].clr,
                  vecs[i].exp_sum, vecs[i].exp_err, vecs[i].exp_err);
        end
        m_err = vecs[5].exp_err;
        s_err = vecs[5].exp_err;

        // out_ack with a mismatching apx while IDLE must not count
        bus.out_ack = 1'b1;
        bus.d__apx  = 17'h1_5555;
        tick();
        tick();
        bus.out_ack = 1'b0;
        chk("ack_ignored_idle", {48'd0, bus.err_cnt}, 64'(m_err));
        chk("ack_ignored_idle_sel", {63'd0, bus.acc__sel}, 64'd0);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            if (i % 5 == 0) rb = ~ra;
            rs = 33'(ra) + 33'(rb);
            rapx = ($urandom_range(0, 1) == 1) ? 17'(rs >> 16) : 17'($urandom);
            model_op(ra, rb, rapx, int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
        end

        // reset during the second ADD cycle
        bus.in_valid = 1'b1;
        bus.a = 32'hDEAD_BEEF;
        bus.b = 32'h1111_1111;
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        chk("rst_add_acc_sel", {63'd0, bus.acc__sel}, 64'd0);
        chk("rst_add_d_acc", {31'd0, bus.d__acc}, 64'd0);
        chk("rst_add_in_ready", {63'd0, bus.in_ready}, 64'd1);
        chk("rst_add_err", {48'd0, bus.err_cnt}, 64'd0);
        m_err = 0;
        s_err = 0;
        tick();
        rst = 1'b1;
        tick();
        do_op(32'd5, 32'd7, 17'h0, 0, 1'b0, 33'd12, 0, 0);

        // reset while the result is held must drop acc__sel before any edge
        bus.in_valid = 1'b1;
        bus.a = 32'h0000_0100;
        bus.b = 32'h0000_0200;
        tick();
        bus.in_valid = 1'b0;
        for (int i = 0; i < 12 && bus.acc__sel !== 1'b1; i++) tick();
        chk("hold_reached", {63'd0, bus.acc__sel}, 64'd1);
        rst = 1'b0;
        #1;
        chk("rst_hold_acc_sel", {63'd0, bus.acc__sel}, 64'd0);
        chk("rst_hold_d_acc", {31'd0, bus.d__acc}, 64'd0);
        tick();
        rst = 1'b1;
        tick();

        // back-to-back mismatches: the narrow twin saturates at 7, then clear
        for (int i = 0; i < 10; i++) begin
            model_op(32'h0001_0000, 32'h0002_0000, 17'h0_0004, 0, 1'b0);
        end
        model_op(32'h0001_0000, 32'h0002_0000, 17'h0_0004, 0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/conf_int_add__acc_supplier.md
# conf_int_add__acc_supplier

Sequential accurate-result producer that feeds the accurate side of the configurable approximate-adder wrapper. It accepts 32-bit operand pairs through a valid/ready handshake and computes the exact 33-bit sum with a chunked, multi-cycle carry chain. It then drives `d__acc` and holds `acc__sel` until the consumer acknowledges. On acknowledge it compares the exact upper bits against the approximate datapath result and keeps a saturating mismatch count.

## Interface
- `DATA_PATH_BITWIDTH`, 16: approximate datapath width. Compare window is `d__acc[32:32-DATA_PATH_BITWIDTH]`.
- `CHUNK_W`, 8: bits added per cycle. Must divide 32. N = 32/CHUNK_W.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  operand pair valid.
- `in_ready`  out  1  block can accept operands.
- `a`  in  32  operand A.
- `b`  in  32  operand B.
- `d__acc`  out  33  exact sum, meaningful while `acc__sel`=1.
- `acc__sel`  out  1  accurate result present; selects `d__acc` in the wrapper.
- `out_ack`  in  1  consumer has taken the result.
- `d__apx`  in  DATA_PATH_BITWIDTH+1  approximate sum from the datapath, sampled on ack.
- `err_clr`  in  1  synchronous clear of `err_cnt`.
- `err_cnt`  out  16  saturating count of upper-bit mismatches.

## Operation
- FSM states: IDLE, ADD, HOLD. Reset state is IDLE.
- IDLE
  - `in_ready`=1.
  - On an edge with `in_valid`=1: capture `a` and `b`, clear carry, clear chunk index, go to ADD.
- ADD
  - `in_ready`=0.
  - Each edge: sum chunk idx = a_chunk + b_chunk + carry; store the CHUNK_W result bits; update carry; idx++.
  - On the edge processing chunk N-1: store the final carry into bit 32, then go to HOLD.
- HOLD
  - `acc__sel`=1 and `d__acc` = full sum, stable throughout.
  - On an edge with `out_ack`=1: compare `d__acc[32:32-DATA_PATH_BITWIDTH]` with `d__apx`. On mismatch, `err_cnt`+1, saturating at 0xFFFF. Then go to IDLE.
- `out_ack` is ignored outside HOLD. `in_valid` is ignored outside IDLE.
- `err_clr`=1 sets `err_cnt` to 0 on that edge and takes priority over a simultaneous increment.
- Outside HOLD, `d__acc` holds its last value. `acc__sel` must be used as its qualifier.
- Reset values: `in_ready`=1, `acc__sel`=0, `d__acc`=0, `err_cnt`=0, state IDLE.
- Reset asserted mid-ADD or mid-HOLD: `acc__sel` drops immediately (asynchronously) and the in-flight operation is discarded.

## Timing
- Operands are accepted on edge E0.
- `acc__sel` rises after edge E_N, the N-th edge after E0 (N=4 by default).
- The earliest `out_ack` is sampled on edge E_N+1. `acc__sel` falls after the ack edge.
- IDLE lasts at least one cycle, so maximum throughput is one operation per N+2 cycles.
- `in_ready` and `acc__sel` are registered state decodes with no combinational path from inputs.
- There is no combinational path from `out_ack` or `in_valid` to any output.

## Structure
- Package `conf_int_add__pkg` holds:
  - the state enum (IDLE/ADD/HOLD);
  - `ACC_W`=33 and `ERR_CNT_W`=16;
  - the derived chunk count N and its index width.
- Sub-module `conf_int_add__chunk_add` is a purely combinational CHUNK_W-bit adder with carry-in and carry-out, instantiated once and reused every ADD cycle.
- The top module holds the FSM, operand and sum registers, carry, index, and the error counter.

## Test plan
- Full carry ripple: a=0xFFFFFFFF, b=0x00000001.
  - Expect `d__acc`=0x1_0000_0000 with `acc__sel` high exactly 4 edges after accept.
  - Expect `in_ready` low during ADD and HOLD.
- Matching compare: a=0x00010000, b=0x00020000, `d__apx`=0x00003, then ack.
  - Expect `err_cnt` to stay 0, `acc__sel` low after the ack edge, and IDLE for one cycle.
- Mismatch: same operands with `d__apx`=0x00004. Expect `err_cnt`=1.
  - Hold `out_ack` low for 5 cycles before acking; `d__acc` must stay 0x0_0003_0000 throughout.
- Clear priority: assert `err_clr` and ack a mismatching result on the same edge. Expect `err_cnt`=0.
- Reset mid-ADD: assert `rst`=0 during the second ADD cycle.
  - Expect `acc__sel`=0, `d__acc`=0, `in_ready`=1 immediately.
  - A subsequent add of 5+7 yields 12.
- Saturation: 65 537 back-to-back mismatching operations. Expect `err_cnt` to stay at 0xFFFF.
